// File: rtl/cpu_ctrl_pkg.sv
// Shared control-path definitions for the CPU sequencers.
//   fetch_state_t : fetch/execute FSM encoding (3-bit)
//   WORD_W        : BUS / register word width
package cpu_ctrl_pkg;
  localparam int WORD_W = 32;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ADDR  = 3'd1,
    READ  = 3'd2,
    EXEC  = 3'd3,
    FAULT = 3'd4
  } fetch_state_t;
endpackage

// File: rtl/fetch_sequencer_if.sv
// Handshake/strobe bundle between the fetch sequencer and the datapath,
// memory and execute unit.
//   master : sequencer side (takes control inputs, drives strobes/status)
//   slave  : environment side (drives control inputs, observes strobes)
interface fetch_sequencer_if;
  import cpu_ctrl_pkg::*;

  // environment -> sequencer
  logic              start;
  logic              halt;
  logic              mem_ack;
  logic              exec_done;
  logic              pc_load;
  // sequencer -> datapath / memory / execute
  logic              R31out;
  logic              MARin;
  logic              mem_req;
  logic              IRin;
  logic              incr_pc;
  logic              R31in;
  logic              exec_start;
  logic              busy;
  logic              fault;
  logic [WORD_W-1:0] instret;

  modport master (
    input  start, halt, mem_ack, exec_done, pc_load,
    output R31out, MARin, mem_req, IRin, incr_pc, R31in,
           exec_start, busy, fault, instret
  );

  modport slave (
    output start, halt, mem_ack, exec_done, pc_load,
    input  R31out, MARin, mem_req, IRin, incr_pc, R31in,
           exec_start, busy, fault, instret
  );
endinterface

// File: rtl/fullAdder32b.sv
// Word-wide ripple-carry adder.
//   a, b : addends      cin  : carry in
//   sum  : a + b + cin  cout : carry out of the top bit
module fullAdder32b
  import cpu_ctrl_pkg::*;
(
  input  logic [WORD_W-1:0] a,
  input  logic [WORD_W-1:0] b,
  input  logic              cin,
  output logic [WORD_W-1:0] sum,
  output logic              cout
);
  logic [WORD_W:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < WORD_W; i++) begin : g_bit
    assign sum[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1]   = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

  assign cout = c[WORD_W];
endmodule

// File: rtl/fetch_sequencer.sv
// Instruction fetch/execute control FSM for the shared BUS datapath.
// Drives R31 (PC), MAR and IR enables, runs a memory read with a timeout
// watchdog, hands the instruction to the execute unit via exec_start /
// exec_done, and counts retired instructions.
//   clk, rst : clock, synchronous active-high reset
//   bus      : fetch_sequencer_if.master (control inputs, strobes, status)
// Parameter MEM_TIMEOUT: READ cycles allowed without mem_ack (0 = no limit).
module fetch_sequencer
  import cpu_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst,
  fetch_sequencer_if.master bus
);
  localparam int WD_W = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

  fetch_state_t      state, state_next;
  logic              exec_first;   // first EXEC cycle: exec_start, done ignored
  logic              halt_pend;
  logic [WD_W-1:0]   wd_cnt;       // completed READ cycles without ack
  logic [WORD_W-1:0] instret_q, instret_inc;
  logic              instret_cout_unused;
  logic              busy_s, retire, wd_expire;

  assign busy_s    = (state == ADDR) || (state == READ) || (state == EXEC);
  assign retire    = (state == EXEC) && !exec_first && bus.exec_done;
  // The current no-ack READ cycle is the MEM_TIMEOUT-th one.
  assign wd_expire = (MEM_TIMEOUT != 0) && (wd_cnt == WD_LAST) && !bus.mem_ack;

  fullAdder32b u_instret_add (
    .a   (instret_q),
    .b   (WORD_W'(1)),
    .cin (1'b0),
    .sum (instret_inc),
    .cout(instret_cout_unused)
  );

  // state register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // next state
  always_comb begin
    state_next = state;
    case (state)
      IDLE:  if (bus.start) state_next = ADDR;
      ADDR:  state_next = READ;
      READ:  begin
        if (bus.mem_ack)    state_next = EXEC;
        else if (wd_expire) state_next = FAULT;
      end
      EXEC:  if (retire) state_next = (halt_pend || bus.halt) ? IDLE : ADDR;
      FAULT: if (bus.start) state_next = ADDR;
      default: state_next = IDLE;
    endcase
  end

  // outputs: Moore decodes plus the READ-ack and retire/branch strobes
  always_comb begin
    bus.R31out     = (state == ADDR);
    bus.MARin      = (state == ADDR);
    bus.mem_req    = (state == READ);
    bus.IRin       = (state == READ) && bus.mem_ack;
    bus.incr_pc    = (state == READ) && bus.mem_ack;
    bus.R31in      = retire && bus.pc_load;
    bus.exec_start = (state == EXEC) && exec_first;
    bus.busy       = busy_s;
    bus.fault      = (state == FAULT);
  end

  assign bus.instret = instret_q;

  // auxiliary state: EXEC-first flag, pending halt, watchdog, retire count
  always_ff @(posedge clk) begin
    if (rst) begin
      exec_first <= 1'b0;
      halt_pend  <= 1'b0;
      wd_cnt     <= '0;
      instret_q  <= '0;
    end else begin
      exec_first <= (state == READ) && bus.mem_ack;

      if (state_next == IDLE)   halt_pend <= 1'b0;
      else if (busy_s && bus.halt) halt_pend <= 1'b1;

      // READ is only ever entered from ADDR, so clearing there clears on entry.
      if (state == ADDR)                        wd_cnt <= '0;
      else if (state == READ && !bus.mem_ack)   wd_cnt <= wd_cnt + WD_W'(1);

      if (retire) instret_q <= instret_inc;
    end
  end
endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer (MEM_TIMEOUT=3). Includes a tiny
// R31/MAR datapath model so PC and address behaviour can be observed.
// Strobe vector order: R31out MARin mem_req IRin incr_pc R31in exec_start busy fault
// Stimulus vector order: rst start halt mem_ack exec_done pc_load
module tb_fetch_sequencer;
  localparam logic [8:0] S_IDL = 9'b000000000;
  localparam logic [8:0] S_ADR = 9'b110000010;
  localparam logic [8:0] S_RD  = 9'b001000010;
  localparam logic [8:0] S_ACK = 9'b001110010;
  localparam logic [8:0] S_EX1 = 9'b000000110;
  localparam logic [8:0] S_EX  = 9'b000000010;
  localparam logic [8:0] S_BR  = 9'b000001010;
  localparam logic [8:0] S_FLT = 9'b000000001;
  localparam logic [31:0] BR_TGT = 32'h0000_0040;

  logic        clk, rst;
  logic [8:0]  strb;
  logic [31:0] r31, mar, bus_val;
  int          total, bad;

  fetch_sequencer_if bif ();

  fetch_sequencer #(.MEM_TIMEOUT(3)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign strb = {bif.R31out, bif.MARin, bif.mem_req, bif.IRin, bif.incr_pc,
                 bif.R31in, bif.exec_start, bif.busy, bif.fault};
  assign bus_val = bif.R31out ? r31 : (bif.pc_load ? BR_TGT : 32'h0);

  always @(posedge clk) begin
    if (rst)              r31 <= 32'h100;
    else if (bif.incr_pc) r31 <= r31 + 32'd1;
    else if (bif.R31in)   r31 <= bus_val;
    if (bif.MARin) mar <= bus_val;
  end

  task automatic test_reset();
    rst = 1'b1;
    {bif.start, bif.halt, bif.mem_ack, bif.exec_done, bif.pc_load} = 5'b0;
    repeat (2) @(negedge clk);
    #1;
    total++;
    if (strb !== S_IDL) begin $display("FAIL reset strobes got=%b exp=%b", strb, S_IDL); bad++; end
    total++;
    if (bif.instret !== 32'h0) begin $display("FAIL reset instret got=%h exp=0", bif.instret); bad++; end
  endtask

  task automatic test_basic();
    logic [5:0]  st [10];
    logic [8:0]  es [10];
    logic [31:0] ei [10];
    st = '{6'b010000, 6'b000000, 6'b000100, 6'b000000, 6'b000010,
           6'b000000, 6'b000100, 6'b001000, 6'b000010, 6'b000000};
    es = '{S_IDL, S_ADR, S_ACK, S_EX1, S_EX, S_ADR, S_ACK, S_EX1, S_EX, S_IDL};
    ei = '{0, 0, 0, 0, 0, 1, 1, 1, 1, 2};
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      {rst, bif.start, bif.halt, bif.mem_ack, bif.exec_done, bif.pc_load} = st[i];
      #1;
      total++;
      if (strb !== es[i]) begin $display("FAIL basic strobes cyc=%0d got=%b exp=%b", i, strb, es[i]); bad++; end
      total++;
      if (bif.instret !== ei[i]) begin $display("FAIL basic instret cyc=%0d got=%h exp=%h", i, bif.instret, ei[i]); bad++; end
    end
    total++;
    if (r31 !== 32'h102) begin $display("FAIL basic r31 got=%h exp=102", r31); bad++; end
    total++;
    if (mar !== 32'h101) begin $display("FAIL basic mar got=%h exp=101", mar); bad++; end
  endtask

  task automatic test_branch();
    logic [5:0]  st [10];
    logic [8:0]  es [10];
    logic [31:0] ei [10];
    st = '{6'b010000, 6'b000000, 6'b000100, 6'b000000, 6'b000011,
           6'b000000, 6'b000100, 6'b001000, 6'b000010, 6'b000000};
    es = '{S_IDL, S_ADR, S_ACK, S_EX1, S_BR, S_ADR, S_ACK, S_EX1, S_EX, S_IDL};
    ei = '{2, 2, 2, 2, 2, 3, 3, 3, 3, 4};
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      {rst, bif.start, bif.halt, bif.mem_ack, bif.exec_done, bif.pc_load} = st[i];
      #1;
      total++;
      if (strb !== es[i]) begin $display("FAIL branch strobes cyc=%0d got=%b exp=%b", i, strb, es[i]); bad++; end
      total++;
      if (bif.instret !== ei[i]) begin $display("FAIL branch instret cyc=%0d got=%h exp=%h", i, bif.instret, ei[i]); bad++; end
      if (i == 5) begin
        total++;
        if (bus_val !== BR_TGT) begin $display("FAIL branch addr_bus got=%h exp=%h", bus_val, BR_TGT); bad++; end
      end
    end
    total++;
    if (r31 !== 32'h41) begin $display("FAIL branch r31 got=%h exp=41", r31); bad++; end
    total++;
    if (mar !== 32'h40) begin $display("FAIL branch mar got=%h exp=40", mar); bad++; end
  endtask

  task automatic test_halt();
    logic [5:0]  st [8];
    logic [8:0]  es [8];
    logic [31:0] ei [8];
    st = '{6'b010000, 6'b000000, 6'b001000, 6'b000100,
           6'b000000, 6'b000010, 6'b000000, 6'b000000};
    es = '{S_IDL, S_ADR, S_RD, S_ACK, S_EX1, S_EX, S_IDL, S_IDL};
    ei = '{4, 4, 4, 4, 4, 4, 5, 5};
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      {rst, bif.start, bif.halt, bif.mem_ack, bif.exec_done, bif.pc_load} = st[i];
      #1;
      total++;
      if (strb !== es[i]) begin $display("FAIL halt strobes cyc=%0d got=%b exp=%b", i, strb, es[i]); bad++; end
      total++;
      if (bif.instret !== ei[i]) begin $display("FAIL halt instret cyc=%0d got=%h exp=%h", i, bif.instret, ei[i]); bad++; end
    end
    total++;
    if (r31 !== 32'h42) begin $display("FAIL halt r31 got=%h exp=42", r31); bad++; end
  endtask

  task automatic test_timeout();
    logic [5:0]  st [14];
    logic [8:0]  es [14];
    logic [31:0] ei [14];
    st = '{6'b010000, 6'b000000, 6'b000000, 6'b000000, 6'b000000,
           6'b000100, 6'b010000, 6'b000000, 6'b000000, 6'b000000,
           6'b000100, 6'b001000, 6'b000010, 6'b000000};
    es = '{S_IDL, S_ADR, S_RD, S_RD, S_RD, S_FLT, S_FLT, S_ADR, S_RD, S_RD,
           S_ACK, S_EX1, S_EX, S_IDL};
    ei = '{5, 5, 5, 5, 5, 5, 5, 5, 5, 5, 5, 5, 5, 6};
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      {rst, bif.start, bif.halt, bif.mem_ack, bif.exec_done, bif.pc_load} = st[i];
      #1;
      total++;
      if (strb !== es[i]) begin $display("FAIL timeout strobes cyc=%0d got=%b exp=%b", i, strb, es[i]); bad++; end
      total++;
      if (bif.instret !== ei[i]) begin $display("FAIL timeout instret cyc=%0d got=%h exp=%h", i, bif.instret, ei[i]); bad++; end
      if (i == 7) begin
        total++;
        if (bus_val !== 32'h42) begin $display("FAIL timeout retry_addr got=%h exp=42", bus_val); bad++; end
      end
    end
    total++;
    if (r31 !== 32'h43) begin $display("FAIL timeout r31 got=%h exp=43", r31); bad++; end
  endtask

  task automatic test_reset_mid_exec();
    logic [5:0]  st [8];
    logic [8:0]  es [8];
    logic [31:0] ei [8];
    st = '{6'b010000, 6'b000000, 6'b000100, 6'b000000,
           6'b100010, 6'b000110, 6'b000110, 6'b000000};
    es = '{S_IDL, S_ADR, S_ACK, S_EX1, S_EX, S_IDL, S_IDL, S_IDL};
    ei = '{6, 6, 6, 6, 6, 0, 0, 0};
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      {rst, bif.start, bif.halt, bif.mem_ack, bif.exec_done, bif.pc_load} = st[i];
      #1;
      total++;
      if (strb !== es[i]) begin $display("FAIL rst_mid strobes cyc=%0d got=%b exp=%b", i, strb, es[i]); bad++; end
      total++;
      if (bif.instret !== ei[i]) begin $display("FAIL rst_mid instret cyc=%0d got=%h exp=%h", i, bif.instret, ei[i]); bad++; end
    end
  endtask

  task automatic test_wrap_ignore();
    logic [5:0]  st [7];
    logic [8:0]  es [7];
    logic [31:0] ei [7];
    @(negedge clk);
    force dut.instret_q = 32'hFFFF_FFFF;
    #1;
    release dut.instret_q;
    // exec_done in the exec_start cycle must not retire
    st = '{6'b010000, 6'b000000, 6'b000100, 6'b000010,
           6'b000000, 6'b001010, 6'b000000};
    es = '{S_IDL, S_ADR, S_ACK, S_EX1, S_EX, S_EX, S_IDL};
    ei = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
           32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0};
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      {rst, bif.start, bif.halt, bif.mem_ack, bif.exec_done, bif.pc_load} = st[i];
      #1;
      total++;
      if (strb !== es[i]) begin $display("FAIL wrap strobes cyc=%0d got=%b exp=%b", i, strb, es[i]); bad++; end
      total++;
      if (bif.instret !== ei[i]) begin $display("FAIL wrap instret cyc=%0d got=%h exp=%h", i, bif.instret, ei[i]); bad++; end
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    mar   = 32'h0;
    test_reset();
    test_basic();
    test_branch();
    test_halt();
    test_timeout();
    test_reset_mid_exec();
    test_wrap_ignore();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
